// File: rtl/mem_byte_ctrl_if.sv
// mem_byte_ctrl_if: CPU-side request/response signals and the byte-wide RAM
// port of mem_byte_ctrl. The master modport is the requester/RAM side, the
// slave modport is the controller.
interface mem_byte_ctrl_if #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17
);
    logic                  inst_req;
    logic [LEN-1:0]        inst_addr;
    logic                  data_req;
    logic                  data_we;
    logic [1:0]            data_size;
    logic                  data_sext;
    logic [LEN-1:0]        data_addr;
    logic [LEN-1:0]        data_wdata;
    logic [7:0]            ram_din;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_dout;
    logic                  ram_wr;
    logic [LEN-1:0]        inst_out;
    logic                  inst_valid;
    logic [LEN-1:0]        data_out;
    logic                  data_valid;
    logic                  busy;

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_size, data_sext,
               data_addr, data_wdata, ram_din,
        input  ram_addr, ram_dout, ram_wr, inst_out, inst_valid, data_out,
               data_valid, busy
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_size, data_sext,
               data_addr, data_wdata, ram_din,
        output ram_addr, ram_dout, ram_wr, inst_out, inst_valid, data_out,
               data_valid, busy
    );
endinterface

// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: serves one fetch or load/store at a time as a byte-serial
// transaction on an 8-bit synchronous RAM (read data one cycle after address).
// Data requests win over fetches. Optional macro MEM_LAST_INST_EN adds a
// one-entry last-fetch buffer that lets a repeated fetch skip the RAM.
//
// state | meaning
// IDLE  | waiting for a request (sampled only when rdy_in=1)
// RD    | issuing read addresses and collecting bytes little-endian
// WR    | issuing write strobes, one byte per cycle
// DONE  | one-cycle valid pulse, then back to IDLE
module mem_byte_ctrl #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17
) (
    input logic             clk,
    input logic             rst,
    input logic             rdy_in,
    mem_byte_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [2:0]            nbytes;
    logic                  is_inst;
    logic                  sext;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0][7:0]       wbytes;
    logic [3:0][7:0]       rbytes;
    logic [LEN-1:0]        inst_q;
    logic [LEN-1:0]        data_q;
    logic [2:0]            lane;
    logic                  active;
`ifdef MEM_LAST_INST_EN
    logic [LEN-1:0]        fetch_tag;
    logic [LEN-1:0]        lb_tag;
    logic [LEN-1:0]        lb_data;
    logic                  lb_valid;
`endif

    function automatic logic [LEN-1:0] extend(input logic [31:0] r,
                                              input logic [2:0] n,
                                              input logic s);
        case (n)
            3'd1:    extend = {{(LEN-8){s & r[7]}}, r[7:0]};
            3'd2:    extend = {{(LEN-16){s & r[15]}}, r[15:0]};
            default: extend = LEN'(r);
        endcase
    endfunction

    assign lane = cnt - 3'd1;

    // Sequencer: request acceptance, byte counting, capture and result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            nbytes  <= '0;
            is_inst <= 1'b0;
            sext    <= 1'b0;
            addr    <= '0;
            wbytes  <= '0;
            rbytes  <= '0;
            inst_q  <= '0;
            data_q  <= '0;
`ifdef MEM_LAST_INST_EN
            fetch_tag <= '0;
            lb_tag    <= '0;
            lb_data   <= '0;
            lb_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rdy_in && bus.data_req) begin
                        is_inst <= 1'b0;
                        sext    <= bus.data_sext;
                        addr    <= bus.data_addr[ADDR_WIDTH-1:0];
                        wbytes  <= bus.data_wdata[31:0];
                        case (bus.data_size)
                            2'd0:    nbytes <= 3'd1;
                            2'd1:    nbytes <= 3'd2;
                            default: nbytes <= 3'd4;
                        endcase
                        state <= bus.data_we ? WR : RD;
`ifdef MEM_LAST_INST_EN
                        if (bus.data_we) lb_valid <= 1'b0;
`endif
                    end else if (rdy_in && bus.inst_req) begin
                        is_inst <= 1'b1;
                        sext    <= 1'b0;
                        addr    <= bus.inst_addr[ADDR_WIDTH-1:0];
                        nbytes  <= 3'd4;
`ifdef MEM_LAST_INST_EN
                        fetch_tag <= bus.inst_addr;
                        if (lb_valid && lb_tag == bus.inst_addr) begin
                            inst_q <= lb_data;
                            state  <= DONE;
                        end else begin
                            state  <= RD;
                        end
`else
                        state <= RD;
`endif
                    end
                end
                RD: begin
                    if (!rdy_in) begin
                        // a stall invalidates the in-flight byte stream; start over
                        cnt <= '0;
                    end else if (cnt == nbytes + 3'd1) begin
                        state <= DONE;
                        if (is_inst) begin
                            inst_q <= extend(rbytes, nbytes, 1'b0);
`ifdef MEM_LAST_INST_EN
                            lb_tag   <= fetch_tag;
                            lb_data  <= extend(rbytes, nbytes, 1'b0);
                            lb_valid <= 1'b1;
`endif
                        end else begin
                            data_q <= extend(rbytes, nbytes, sext);
                        end
                    end else begin
                        if (cnt != 3'd0) rbytes[lane[1:0]] <= bus.ram_din;
                        cnt <= cnt + 3'd1;
                    end
                end
                WR: begin
                    if (rdy_in) begin
                        if (cnt == nbytes) state <= DONE;
                        else               cnt   <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // RAM port, valid pulses and busy decoded from the current state.
    always_comb begin
        active         = (state == RD || state == WR) && (cnt < nbytes);
        bus.busy       = (state != IDLE);
        bus.inst_valid = (state == DONE) && is_inst;
        bus.data_valid = (state == DONE) && !is_inst;
        bus.ram_addr   = active ? addr + ADDR_WIDTH'(cnt) : '0;
        bus.ram_wr     = active && (state == WR) && rdy_in;
        bus.ram_dout   = bus.ram_wr ? wbytes[cnt[1:0]] : 8'h00;
        bus.inst_out   = inst_q;
        bus.data_out   = data_q;
    end
endmodule

// File: tb/tb_mem_byte_ctrl.sv
// tb_mem_byte_ctrl: directed and randomized checks of mem_byte_ctrl against a
// byte-array memory model and a transaction-level timing model.
module tb_mem_byte_ctrl;
    localparam int LEN  = 32;
    localparam int AW   = 17;
    localparam int MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic rdy_in;

    mem_byte_ctrl_if #(.LEN(LEN), .ADDR_WIDTH(AW)) bus ();

    mem_byte_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:MASK];
    logic [7:0] ref_mem [0:MASK];

    // RAM with one-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;
    bit lb_valid = 1'b0;
    logic [31:0] lb_tag = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit s);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(ref_mem[(a + i) & MASK]) << (8 * i);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic bit would_hit(input logic [31:0] a);
`ifdef MEM_LAST_INST_EN
        return lb_valid && lb_tag == a;
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_sext  = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
    endtask

    task automatic do_txn(input bit is_fetch, input bit we, input int size, input bit s,
                          input logic [31:0] a, input logic [31:0] wd, input int stall_at,
                          input string tag);
        int n, lat_exp, lat;
        bit hit, bad_other, bad_busy, bad_wr;
        logic [31:0] exp_val, a_k, b_k;
        n = is_fetch ? 4 : (size == 0 ? 1 : (size == 1 ? 2 : 4));
        hit = is_fetch && would_hit(a);
        lat_exp = hit ? 1 : (we ? n + 2 : n + 3);
        if (stall_at != 0) lat_exp = stall_at + 2 + n + 3;
        exp_val = ref_load(a, n, s && !is_fetch);
        lat = -1; bad_other = 0; bad_busy = 0; bad_wr = 0;
        @(negedge clk);
        if (is_fetch) begin
            bus.inst_req = 1'b1; bus.inst_addr = a;
        end else begin
            bus.data_req = 1'b1; bus.data_we = we; bus.data_size = size[1:0];
            bus.data_sext = s; bus.data_addr = a; bus.data_wdata = wd;
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (stall_at == 0 && !hit && k <= n) begin
                a_k = (a + k - 1) & MASK;
                check({tag, "_addr"}, 32'(bus.ram_addr), a_k);
                if (we) begin
                    b_k = (wd >> (8 * (k - 1))) & 32'hFF;
                    check({tag, "_wr"}, 32'(bus.ram_wr), 32'd1);
                    check({tag, "_dout"}, 32'(bus.ram_dout), b_k);
                end
            end
            if (hit && k == 1) check({tag, "_hit_addr"}, 32'(bus.ram_addr), 32'd0);
            if (!we && bus.ram_wr) bad_wr = 1;
            if (we && k > n && bus.ram_wr) bad_wr = 1;
            if (!bus.busy) bad_busy = 1;
            if (is_fetch ? bus.data_valid : bus.inst_valid) bad_other = 1;
            if (is_fetch ? bus.inst_valid : bus.data_valid) begin
                lat = k;
                break;
            end
            if (stall_at != 0 && k == stall_at) rdy_in = 1'b0;
            if (stall_at != 0 && k == stall_at + 3) rdy_in = 1'b1;
        end
        if (is_fetch) check({tag, "_inst"}, bus.inst_out, exp_val);
        else if (!we) check({tag, "_data"}, bus.data_out, exp_val);
        idle_inputs();
        rdy_in = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_flags"}, {29'd0, bad_wr, bad_busy, bad_other}, 32'd0);
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, bus.busy, bus.inst_valid | bus.data_valid}, 32'd0);
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[(a + i) & MASK] = wd[8*i +: 8];
            lb_valid = 1'b0;
        end
        if (is_fetch && lat != -1) begin
            lb_valid = 1'b1;
            lb_tag   = a;
        end
    endtask

    initial begin
        logic [31:0] dval, exp_d, exp_i, ra;
        int kd, ki, idle_cnt, kind, n_b;
        bit hit, seen;
        logic [7:0] b;

        for (int i = 0; i <= MASK; i++) begin
            b = 8'($urandom);
            ram[i] = b;
            ref_mem[i] = b;
        end
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h10; ref_mem[32'h103] = 8'h00;
        ram[32'h20] = 8'h80; ref_mem[32'h20] = 8'h80;

        idle_inputs();
        rdy_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.inst_valid, bus.data_valid, bus.ram_wr, 28'd0}, 32'd0);
        check("reset_inst_out", bus.inst_out, 32'd0);
        check("reset_addr", 32'(bus.ram_addr), 32'd0);
        rst = 1'b0;

        do_txn(1, 0, 2, 0, 32'h100, 0, 0, "fetch100");
        check("fetch100_const", bus.inst_out, 32'h00100513);
        do_txn(0, 0, 0, 1, 32'h20, 0, 0, "lb_sext");
        check("lb_sext_const", bus.data_out, 32'hFFFFFF80);
        do_txn(0, 0, 0, 0, 32'h20, 0, 0, "lb_zext");
        check("lb_zext_const", bus.data_out, 32'h00000080);
        do_txn(0, 1, 1, 0, 32'h1FFFF, 32'hDEADBEEF, 0, "sh_wrap");
        do_txn(0, 0, 1, 0, 32'h1FFFF, 0, 0, "lh_wrap");
        check("lh_wrap_const", bus.data_out, 32'h0000BEEF);
        do_txn(0, 0, 2, 0, 32'h40, 0, 4, "lw_stall");

        // simultaneous load word and fetch
        @(negedge clk);
        hit = would_hit(32'h104);
        exp_d = ref_load(32'h60, 4, 0);
        exp_i = ref_load(32'h104, 4, 0);
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h60;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h104;
        kd = -1; ki = -1; idle_cnt = 0; dval = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!bus.busy) idle_cnt++;
            if (bus.data_valid && kd < 0) begin
                kd = k; dval = bus.data_out; bus.data_req = 1'b0;
            end
            if (bus.inst_valid) begin
                ki = k; bus.inst_req = 1'b0;
                break;
            end
        end
        idle_inputs();
        check("simul_data_lat", 32'(kd), 32'd7);
        check("simul_inst_lat", 32'(ki), hit ? 32'd9 : 32'd15);
        check("simul_idle_cycles", 32'(idle_cnt), 32'd1);
        check("simul_data", dval, exp_d);
        check("simul_inst", bus.inst_out, exp_i);
        if (ki != -1) begin lb_valid = 1'b1; lb_tag = 32'h104; end
        @(negedge clk);

        // reset in the middle of a fetch
        bus.inst_req = 1'b1; bus.inst_addr = 32'h208;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        check("midrst_ctl", {bus.busy, bus.inst_valid, bus.data_valid, bus.ram_wr, 28'd0}, 32'd0);
        check("midrst_addr", 32'(bus.ram_addr), 32'd0);
        check("midrst_inst_out", bus.inst_out, 32'd0);
        check("midrst_data_out", bus.data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lb_valid = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.inst_valid || bus.data_valid || bus.busy) seen = 1'b1;
        end
        check("midrst_quiet", 32'(seen), 32'd0);

        // repeated fetch, then invalidation by a store
        do_txn(1, 0, 2, 0, 32'h100, 0, 0, "refetch_a");
        do_txn(1, 0, 2, 0, 32'h100, 0, 0, "refetch_b");
        do_txn(0, 1, 2, 0, 32'h300, 32'h12345678, 0, "sw_inval");
        do_txn(1, 0, 2, 0, 32'h100, 0, 0, "refetch_c");
        do_txn(0, 0, 2, 0, 32'h300, 0, 0, "lw_back");
        check("lw_back_const", bus.data_out, 32'h12345678);

        // randomized mix over a small address window, with high bits set
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            n_b = $urandom_range(0, 2);
            ra = ($urandom_range(0, 1) ? 32'h0001_FFF0 : 32'h0000_0300) + $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) ra = ra | 32'h00A6_0000;
            if (kind == 0)
                do_txn(1, 0, 2, 0, ($urandom_range(0, 1) ? 32'h100 : 32'h0001_FFFE), 0, 0, "rnd_fetch");
            else if (kind == 1)
                do_txn(0, 0, n_b, 1'($urandom_range(0, 1)), ra, 0, 0, "rnd_load");
            else
                do_txn(0, 1, n_b, 0, ra, $urandom, 0, "rnd_store");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_byte_ctrl.md
Name: mem_byte_ctrl

Overview:
- Memory-side responder for the CPU's instruction-fetch and data-access requests.
- Converts each word, halfword or byte request into a byte-serial transaction on the 8-bit synchronous RAM port.
- Assembles read bytes little-endian, sign- or zero-extends loads, and returns the result with a one-cycle valid pulse.
- Sits between the fetch/load-store units and the RAM: one outstanding request at a time, data port has priority over instruction port.

Parameters:
- LEN, 32, width of addresses and data words.
- ADDR_WIDTH, 17, RAM address width; request addresses are truncated to their low ADDR_WIDTH bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; low = stall.
- inst_req  in  1  instruction fetch request, level, held until inst_valid.
- inst_addr  in  LEN  fetch address.
- data_req  in  1  data request, level, held until data_valid.
- data_we  in  1  1 = store, 0 = load.
- data_size  in  2  0 byte, 1 half, 2 or 3 word.
- data_sext  in  1  load sign-extend enable.
- data_addr  in  LEN  data address.
- data_wdata  in  LEN  store data, low bytes used.
- ram_din  in  8  RAM read byte; 1-cycle latency after ram_addr.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr  out  1  RAM write strobe.
- inst_out  out  LEN  fetched instruction, valid with inst_valid, held afterwards.
- inst_valid  out  1  one-cycle pulse.
- data_out  out  LEN  load result, valid with data_valid, held afterwards.
- data_valid  out  1  one-cycle pulse, for loads and stores.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; byte counter 0; all outputs 0; in-flight transaction dropped. Requesters must re-issue.
- FSM states: IDLE, RD, WR, DONE.
- IDLE acceptance: requests are sampled only in IDLE, at a clock edge with rdy_in=1.
  - data_req wins over inst_req.
  - Request fields are latched at the accept edge (cycle 0).
  - N = 1, 2 or 4 from data_size; fetch always uses N=4.
- RD state:
  - In cycle i+1 (i = 0..N-1), ram_addr = (addr+i)[ADDR_WIDTH-1:0]. Address wraps modulo 2^ADDR_WIDTH; misalignment is allowed.
  - ram_din is captured at the end of cycle i+2 into byte lane i (little-endian).
  - DONE is entered after the last capture, so the valid pulse occurs in cycle N+3.
  - Word fetch: inst_valid in cycle 7 after accept.
- WR state:
  - In cycle i+1, ram_wr=1, ram_addr=(addr+i)[ADDR_WIDTH-1:0], ram_dout=data_wdata[8i+7:8i].
  - data_valid pulses in cycle N+2.
  - ram_wr is 0 in every other cycle.
- Load extension: byte/half results are sign-extended from bit 7/15 when data_sext=1, else zero-extended. Word results pass through.
- DONE: pulses exactly one valid output for one cycle, then returns to IDLE unconditionally. Requester must deassert req in the cycle after valid.
- busy is 0 only in IDLE.
- rdy_in=0:
  - FSM, counter and outputs hold; ram_wr forced 0.
  - Pending reads restart from byte 0 on resume, discarding captured bytes.
  - Pending writes resume at the current byte.
- Simultaneous inst_req and data_req in IDLE: data is served first; fetch is served on the next IDLE acceptance while inst_req is still held.
- Reset mid-transaction: partial writes already issued remain in RAM; no valid pulse is generated.

Optional Feature:
- Macro: MEM_LAST_INST_EN.
- Defined:
  - Adds a one-entry buffer (tag = full inst_addr, data, valid bit), filled on every completed fetch.
  - An accepted fetch that hits a valid buffer entry goes straight to DONE: inst_valid in cycle 1, no RAM access.
  - Any accepted store or reset clears the valid bit.
- Undefined: no buffer; every fetch performs 4 RAM reads.

Test Plan:
- Word fetch: inst_req, inst_addr=0x100, RAM[0x100..0x103]=13,05,10,00 -> inst_out=0x00100513; inst_valid in cycle 7; ram_addr sequence 0x100..0x103 in cycles 1-4.
- Signed byte load: data_addr=0x20, size=0, sext=1, RAM[0x20]=0x80 -> data_out=0xFFFFFF80. Same with sext=0 -> 0x00000080.
- Halfword store: data_we=1, size=1, data_addr=0x1FFFF, wdata=0xDEADBEEF -> ram_wr pulses 2 cycles: (0x1FFFF,0xEF), then wrapped (0x00000,0xBE); data_valid in cycle 4.
- Simultaneous requests: inst_req and data_req (load word) both high in IDLE -> data_valid precedes inst_valid; busy stays high except for one IDLE cycle in between.
- Stall: rdy_in=0 for 3 cycles during word read after byte 1 captured -> no ram_wr; read restarts at byte 0 on resume; correct word returned.
- Reset mid-op and MEM_LAST_INST_EN: rst pulsed mid-fetch -> outputs 0, IDLE, no valid. With macro defined, repeat fetch of 0x100 -> inst_valid in cycle 1, no ram_addr activity; after a store, fetch of 0x100 -> full 4-byte read again.
